// File: rtl/uart_host_master.sv
// uart_host_master
// Host-side initiator for the UART register protocol. A parallel register
// command becomes one or two 8N1 frames on uart_txd_o; a read then waits for a
// one-byte reply on uart_rxd_i.
//
// Ports
//   clk_i        system clock
//   rst_i        synchronous reset, active-high
//   cmd_valid_i  command offered
//   cmd_ready_o  master idle
//   cmd_write_i  1 = write, 0 = read
//   cmd_addr_i   7-bit register address
//   cmd_wdata_i  write data (ignored for reads)
//   rsp_valid_o  one-cycle completion pulse
//   rsp_rdata_o  read data, held until the next completion
//   rsp_err_o    qualifies rsp_valid_o: read timeout or framing error
//   uart_txd_o   serial out, idle high
//   uart_rxd_i   serial in, asynchronous
//
// Handshake: a command transfers on a rising edge where cmd_valid_i and
// cmd_ready_o are both high. cmd_ready_o stays low from that edge until the
// completion pulse; rsp_valid_o is high for exactly one cycle per accepted
// command, in the cycle where cmd_ready_o has just returned high.
module uart_host_master #(
  parameter int CLK_FREQ   = 24_000_000,
  parameter int BAUD       = 115_200,
  parameter int RD_TIMEOUT = 2_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_write_i,
  input  logic [6:0] cmd_addr_i,
  input  logic [7:0] cmd_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic       rsp_err_o,
  output logic       uart_txd_o,
  input  logic       uart_rxd_i
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int BW  = $clog2(DIV);
  localparam int TW  = $clog2(RD_TIMEOUT + 1);

  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [BW-1:0] BAUD_MID  = BW'(DIV / 2);
  localparam logic [TW-1:0] TMO_LAST  = TW'(RD_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(RD_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, TX_HDR, TX_DAT, RX_WAIT, RX_BIT, DONE
  } state_t;

  state_t        state, state_n;
  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_idx;
  logic [TW-1:0] tmo_cnt;
  logic          wr_q;
  logic [6:0]    addr_q;
  logic [7:0]    wdata_q;
  logic [2:0]    rx_sync;
  logic [7:0]    rx_shift;
  logic          err_q;

  logic          bit_end, mid_bit, rx_bit, rx_fall;
  logic          done_err, shift_en;
  logic [9:0]    tx_frame;

  assign bit_end = (baud_cnt == BAUD_LAST);
  assign mid_bit = (baud_cnt == BAUD_MID);
  // rx_sync[1] is the synchronised line; rx_sync[2] is its previous value.
  assign rx_bit  = rx_sync[1];
  assign rx_fall = rx_sync[2] & ~rx_sync[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    cmd_ready_o = 1'b0;
    uart_txd_o  = 1'b1;
    done_err    = 1'b0;
    shift_en    = 1'b0;
    tx_frame    = {1'b1, (state == TX_DAT) ? wdata_q : {wr_q, addr_q}, 1'b0};
    case (state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_n = TX_HDR;
      end
      TX_HDR: begin
        uart_txd_o = tx_frame[bit_idx];
        if (bit_end && bit_idx == 4'd9) state_n = wr_q ? TX_DAT : RX_WAIT;
      end
      TX_DAT: begin
        uart_txd_o = tx_frame[bit_idx];
        if (bit_end && bit_idx == 4'd9) state_n = DONE;
      end
      RX_WAIT: begin
        // Timeout wins over a coincident start edge.
        if (tmo_cnt >= TMO_LAST) begin
          state_n  = DONE;
          done_err = 1'b1;
        end else if (rx_fall) begin
          state_n = RX_BIT;
        end
      end
      RX_BIT: begin
        if (mid_bit) begin
          if (bit_idx == 4'd0) begin
            // Start bit high at mid-bit: glitch, resume waiting.
            if (rx_bit) state_n = RX_WAIT;
          end else if (bit_idx == 4'd9) begin
            state_n  = DONE;
            done_err = ~rx_bit;
          end else begin
            shift_en = 1'b1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      baud_cnt    <= '0;
      bit_idx     <= '0;
      tmo_cnt     <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rx_sync     <= 3'b111;
      rx_shift    <= '0;
      err_q       <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      rx_sync     <= {rx_sync[1:0], uart_rxd_i};
      rsp_valid_o <= (state == DONE);

      if (cmd_valid_i && cmd_ready_o) begin
        wr_q    <= cmd_write_i;
        addr_q  <= cmd_addr_i;
        wdata_q <= cmd_wdata_i;
      end

      // Bit timing restarts on every state change.
      if (state_n != state) begin
        baud_cnt <= '0;
        bit_idx  <= '0;
      end else if (state inside {TX_HDR, TX_DAT, RX_BIT}) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
        if (bit_end) bit_idx <= bit_idx + 4'd1;
      end

      // Runs across glitch retries; only a new command clears it.
      if (state inside {RX_WAIT, RX_BIT}) begin
        if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end

      if (shift_en) rx_shift <= {rx_bit, rx_shift[7:1]};

      if (state_n == DONE && state != DONE) err_q <= done_err;

      if (state == DONE) begin
        rsp_err_o <= err_q;
        if (!wr_q && !err_q) rsp_rdata_o <= rx_shift;
      end
    end
  end

endmodule

// File: tb/tb_uart_host_master.sv
// tb_uart_host_master
// Drives register commands into uart_host_master, decodes its serial output,
// plays the target side of the link and checks responses against a
// register-file model kept in the bench.
module tb_uart_host_master;

  localparam int DIV = 16;
  localparam int TMO = 400;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       txd;
  logic       rxd = 1'b1;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_host_master #(.CLK_FREQ(16), .BAUD(1), .RD_TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .uart_txd_o(txd), .uart_rxd_i(rxd)
  );

  // ---------------- model state ----------------
  typedef struct {
    bit         is_rd;
    logic [7:0] rdata;
    bit         err;
    int         due;
  } rsp_t;

  rsp_t       rsp_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_log[$];
  logic [6:0] tgt_q[$];
  logic [7:0] model_mem[128];
  logic [7:0] tgt_mem[128];
  logic [7:0] model_rdata = '0;
  bit         model_busy = 1'b0;
  bit         last_rsp_err = 1'b0;
  int         last_rsp_cyc = 0;
  int         last_acc = 0;
  int         mon_skip = 0;
  int         tgt_mode = 0;
  bit         tgt_busy = 1'b0;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin : cmp
    rsp_t r;
    if (!rst) begin
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", rsp_q.size(), 1);
        end else begin
          r = rsp_q.pop_front();
          check("rsp_err", rsp_err, r.err);
          if (r.due >= 0) check("rsp_cycle", cyc, r.due);
          if (r.is_rd && !r.err) model_rdata = r.rdata;
        end
        model_busy   = 1'b0;
        last_rsp_cyc = cyc;
        last_rsp_err = rsp_err;
      end
      check("ready", cmd_ready, !model_busy);
      check("rdata_hold", rsp_rdata, model_rdata);
      if (!model_busy) check("txd_idle", txd, 1);
    end
  end

  // ---------------- serial monitor on txd ----------------
  initial begin : mon
    logic [7:0] b;
    logic [6:0] wa;
    logic       stopb;
    bit         eh;
    eh = 1'b1;
    wa = '0;
    forever begin
      @(negedge clk);
      if (!rst && txd === 1'b0) begin
        repeat (7) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
          repeat (DIV) @(negedge clk);
          b[j] = txd;
        end
        repeat (DIV) @(negedge clk);
        stopb = txd;
        if (mon_skip > 0) begin
          mon_skip--;
          eh = 1'b1;
        end else begin
          check("tx_stop", stopb, 1);
          got_log.push_back(b);
          if (exp_q.size() == 0) check("tx_byte_unexp", exp_q.size(), 1);
          else check("tx_byte", b, exp_q.pop_front());
          if (eh) begin
            if (b[7]) begin
              eh = 1'b0;
              wa = b[6:0];
            end else begin
              tgt_q.push_back(b[6:0]);
            end
          end else begin
            tgt_mem[wa] = b;
            eh = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- target model on rxd ----------------
  task automatic send_byte(input logic [7:0] b, input logic stopv);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      rxd = b[j];
      repeat (DIV) @(negedge clk);
    end
    rxd = stopv;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
  endtask

  initial begin : tgt
    logic [6:0] a;
    forever begin
      @(negedge clk);
      if (tgt_q.size() > 0) begin
        a = tgt_q.pop_front();
        tgt_busy = 1'b1;
        case (tgt_mode)
          0: begin repeat (50) @(negedge clk); send_byte(tgt_mem[a], 1'b1); end
          2: begin repeat (50) @(negedge clk); send_byte(tgt_mem[a], 1'b0); end
          3: begin
            repeat (20) @(negedge clk);
            rxd = 1'b0;
            repeat (3) @(negedge clk);
            rxd = 1'b1;
            repeat (30) @(negedge clk);
            send_byte(tgt_mem[a], 1'b1);
          end
          default: ;
        endcase
        tgt_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after acceptance.
  task automatic do_cmd(input bit w, input logic [6:0] a, input logic [7:0] d,
                        input bit eerr, input int due_rel);
    int   n;
    rsp_t r;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      check("accept_timeout", n, 0);
      cmd_valid = 1'b0;
      return;
    end
    last_acc = cyc;
    @(posedge clk);
    #1;
    model_busy = 1'b1;
    exp_q.push_back({w, a});
    if (w) exp_q.push_back(d);
    r.is_rd = !w;
    r.err   = eerr;
    r.rdata = model_mem[a];
    r.due   = (due_rel < 0) ? -1 : last_acc + due_rel;
    rsp_q.push_back(r);
    if (w) model_mem[a] = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((rsp_q.size() > 0 || model_busy || exp_q.size() > 0 || tgt_busy ||
            tgt_q.size() > 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) check("idle_timeout", n, 0);
    repeat (20) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int         base, prev;
    logic [7:0] v, old;
    for (int i = 0; i < 128; i++) begin
      v = 8'($urandom_range(0, 255));
      model_mem[i] = v;
      tgt_mem[i]   = v;
    end

    repeat (4) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", rsp_err, 0);
    rst = 1'b0;

    // 1: single write, fixed latency
    base = got_log.size();
    do_cmd(1'b1, 7'h20, 8'hA5, 1'b0, 20 * DIV + 2);
    wait_idle();
    if (got_log.size() >= base + 2) begin
      check("t1_hdr", got_log[base], 8'hA0);
      check("t1_dat", got_log[base+1], 8'hA5);
    end else check("t1_bytes", got_log.size(), base + 2);
    check("t1_latency", last_rsp_cyc - last_acc, 322);

    // 2: read with reply
    model_mem[7'h40] = 8'h3C;
    tgt_mem[7'h40]   = 8'h3C;
    tgt_mode = 0;
    base = got_log.size();
    do_cmd(1'b0, 7'h40, 8'h00, 1'b0, -1);
    wait_idle();
    if (got_log.size() >= base + 1) check("t2_hdr", got_log[base], 8'h40);
    else check("t2_bytes", got_log.size(), base + 1);
    check("t2_rdata", rsp_rdata, 8'h3C);
    check("t2_err", last_rsp_err, 0);

    // 3: read, no reply -> timeout
    tgt_mode = 1;
    do_cmd(1'b0, 7'h41, 8'h00, 1'b1, 10 * DIV + TMO + 2);
    wait_idle();
    check("t3_latency", last_rsp_cyc - last_acc, 562);
    check("t3_err", last_rsp_err, 1);
    check("t3_rdata", rsp_rdata, 8'h3C);

    // 4a: reply with bad stop bit
    tgt_mode = 2;
    do_cmd(1'b0, 7'h42, 8'h00, 1'b1, -1);
    wait_idle();
    check("t4_err", last_rsp_err, 1);
    check("t4_rdata", rsp_rdata, 8'h3C);

    // 4b: glitch ahead of a valid reply
    model_mem[7'h43] = 8'h5A;
    tgt_mem[7'h43]   = 8'h5A;
    tgt_mode = 3;
    do_cmd(1'b0, 7'h43, 8'h00, 1'b0, -1);
    wait_idle();
    check("t4g_rdata", rsp_rdata, 8'h5A);
    check("t4g_err", last_rsp_err, 0);
    tgt_mode = 0;

    // 5: reset during bit 3 of a write header
    old = model_mem[7'h22];
    do_cmd(1'b1, 7'h22, 8'h11, 1'b0, -1);
    repeat (3 * DIV + 4) @(negedge clk);
    rst = 1'b1;
    mon_skip = 1;
    model_busy = 1'b0;
    model_rdata = '0;
    rsp_q.delete();
    exp_q.delete();
    model_mem[7'h22] = old;
    @(negedge clk);
    check("t5_txd", txd, 1);
    check("t5_ready", cmd_ready, 1);
    check("t5_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    do_cmd(1'b1, 7'h22, 8'h66, 1'b0, 20 * DIV + 2);
    wait_idle();
    do_cmd(1'b0, 7'h22, 8'h00, 1'b0, -1);
    wait_idle();
    check("t5_readback", rsp_rdata, 8'h66);

    // 6: back-to-back stream
    do_cmd(1'b1, 7'h00, 8'($urandom_range(0, 255)), 1'b0, 20 * DIV + 2);
    for (int i = 0; i < 32; i++) begin
      prev = last_acc;
      do_cmd(1'b1, 7'h21, 8'($urandom_range(0, 255)), 1'b0, 20 * DIV + 2);
      check("b2b_gap", last_acc - prev, 20 * DIV + 2);
    end
    do_cmd(1'b1, 7'h30, 8'($urandom_range(0, 255)), 1'b0, 20 * DIV + 2);
    for (int i = 0; i < 16; i++) do_cmd(1'b0, 7'(8'h40 + i), 8'h00, 1'b0, -1);
    wait_idle();

    // random mix
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1)
        do_cmd(1'b1, 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)), 1'b0, 20 * DIV + 2);
      else
        do_cmd(1'b0, 7'($urandom_range(0, 127)), 8'h00, 1'b0, -1);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    wait_idle();
    check("bytes_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
